dvp_frame_gen: RTL
==================

Name: dvp_frame_gen

Overview:
- Transmit side of the camera DVP interface: generates vsync/href/data byte streams frame by frame, exactly as the sensor drives them into the cam_counter-style receivers.
- Used as an on-FPGA camera emulator for bring-up and for regression of the capture path without a sensor attached.
- Produces a deterministic test pattern, so receivers can check byte counts and byte values.

Parameters:
- LINE_BYTES, 1280, bytes per active line (href-high clocks per line); range 1..2047
- LINES, 480, active lines per frame; range 1..1023
- VSYNC_CLKS, 4704, clocks vsync is held high; range 1..65535
- VBP_CLKS, 26656, clocks from vsync fall to first href rise; range 1..65535
- HBLANK_CLKS, 288, href-low clocks between active lines; range 1..65535
- VFP_CLKS, 15680, clocks from last href fall to end of frame; range 1..65535

Ports:
- pclk  in  1  single clock; all outputs change on its rising edge
- reset  in  1  synchronous, active-low reset (asserted when 0)
- start  in  1  begin one frame when idle (level-sampled)
- continuous  in  1  1 = start the next frame immediately after frame end
- vsync  out  1  frame sync, active high
- href  out  1  byte-valid line strobe, active high
- data  out  8  pixel byte, valid while href=1, 0x00 otherwise
- busy  out  1  1 in any state other than IDLE
- frame_done  out  1  one-cycle pulse at end of frame
- frame_count  out  16  completed-frame counter

Behaviour:
- All outputs are registered. Reset (reset=0 at a pclk edge) sets: state=IDLE; vsync=0, href=0, data=0x00, busy=0, frame_done=0, frame_count=0; internal timer, byte counter and line counter=0. Reset mid-frame aborts the frame on that edge; no frame_done is produced.
- State machine states: IDLE, VSYNC, VBP, ACTIVE, HBLANK, VFP.
- IDLE: if start=1 is sampled at edge N, vsync=1 from N+1. start is ignored outside IDLE.
- VSYNC: vsync=1 for exactly VSYNC_CLKS cycles, then VBP.
- VBP: all outputs low for VBP_CLKS cycles, then ACTIVE with line=0.
- ACTIVE: href=1 for exactly LINE_BYTES consecutive cycles.
  - data = (line + byte) mod 256, where byte counts 0..LINE_BYTES-1 within the line.
  - After the last byte: HBLANK if line<LINES-1, else VFP.
- HBLANK: href=0, data=0x00 for HBLANK_CLKS cycles. Then line increments and the state returns to ACTIVE.
- VFP: outputs low for VFP_CLKS cycles.
- Frame end: on the cycle after the last VFP cycle, frame_done=1 for one cycle and frame_count increments (wraps 0xFFFF->0x0000).
  - If continuous=1 on that edge, the state goes to VSYNC and vsync=1 in the same cycle as frame_done; busy stays 1.
  - Otherwise the state goes to IDLE with busy=0. An asserted start then begins a new frame in the same way as above.
- Frame period = VSYNC_CLKS + VBP_CLKS + LINES*LINE_BYTES + (LINES-1)*HBLANK_CLKS + VFP_CLKS clocks.
- vsync and href are never high simultaneously.
- Counters saturate never: widths are sized to the parameter ranges above.

Optional Feature:
- Macro: DVP_EXT_PIXEL_EN.
- Defined: adds ports pix_data (in, 8), pix_valid (in, 1), pix_ready (out, 1), underflow (out, 1).
  - pix_ready=1 in the cycle before each href-high cycle. A byte is accepted when pix_ready and pix_valid are both 1 and appears on data in the next cycle with href=1.
  - If pix_valid=0 when pix_ready=1, data=0x00 for that byte and underflow is set. underflow is sticky, is cleared on frame start and on reset, and href timing is unaffected.
- Not defined: the internal (line+byte) pattern is used and the extra ports do not exist.

Test Plan (params LINE_BYTES=4, LINES=2, VSYNC_CLKS=2, VBP_CLKS=3, HBLANK_CLKS=2, VFP_CLKS=1):
- Single frame: start=1 for one cycle at edge 0.
  -> vsync high on cycles 1-2; href high on cycles 6-9 with data 00,01,02,03; href high on cycles 12-15 with data 01,02,03,04.
  -> frame_done at cycle 17; frame_count=1; busy=0 from cycle 17.
- Continuous: continuous=1, start once.
  -> frame_done every 16 cycles, with vsync=1 coincident with each frame_done; after 3 frames frame_count=3.
- Start ignored: pulse start during ACTIVE.
  -> timing identical to the single-frame case; exactly one frame_done.
- Reset mid-frame: reset=0 at cycle 7.
  -> cycle 8: href=0, data=0x00, busy=0, frame_count=0; no frame_done; a subsequent start reproduces the single-frame timing.
- Wrap: preload frame_count to 0xFFFF via force, complete a frame.
  -> frame_count=0x0000.
- DVP_EXT_PIXEL_EN: feed 0xA0..0xA7 with pix_valid=1, then repeat the frame with pix_valid=0 on the 3rd byte.
  -> data matches the fed bytes and underflow=0; second frame: third byte=0x00, underflow=1; underflow clears at the next start.

Source files
------------

// File: rtl/dvp_frame_gen_if.sv
// DVP byte-stream bundle: vsync/href/data as driven by a sensor (or its emulator).
interface dvp_frame_gen_if;
  logic       vsync;
  logic       href;
  logic [7:0] data;

  modport master (output vsync, output href, output data);
  modport slave  (input  vsync, input  href, input  data);
endinterface

// File: rtl/dvp_frame_gen.sv
// DVP transmit-side frame generator (camera emulator) with a (line+byte) test pattern.
// Define DVP_EXT_PIXEL_EN to source pixel bytes from the pix_data/pix_valid/pix_ready stream instead.
//
// state  | meaning
// IDLE   | waiting for start
// VSYNC  | vsync high, VSYNC_CLKS cycles
// VBP    | vertical back porch, VBP_CLKS cycles
// ACTIVE | href high, one byte per clock, LINE_BYTES cycles
// HBLANK | href low between lines, HBLANK_CLKS cycles
// VFP    | vertical front porch, VFP_CLKS cycles
module dvp_frame_gen #(
  parameter int LINE_BYTES  = 1280,
  parameter int LINES       = 480,
  parameter int VSYNC_CLKS  = 4704,
  parameter int VBP_CLKS    = 26656,
  parameter int HBLANK_CLKS = 288,
  parameter int VFP_CLKS    = 15680
) (
  input  logic                   pclk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   continuous,
  dvp_frame_gen_if.master        dvp,
  output logic                   busy,
  output logic                   frame_done,
  output logic [15:0]            frame_count
`ifdef DVP_EXT_PIXEL_EN
  ,
  input  logic [7:0]             pix_data,
  input  logic                   pix_valid,
  output logic                   pix_ready,
  output logic                   underflow
`endif
);

  typedef enum logic [2:0] {IDLE, VSYNC, VBP, ACTIVE, HBLANK, VFP} state_t;

  localparam logic [15:0] VSYNC_LD  = 16'(VSYNC_CLKS - 1);
  localparam logic [15:0] VBP_LD    = 16'(VBP_CLKS - 1);
  localparam logic [15:0] HBLANK_LD = 16'(HBLANK_CLKS - 1);
  localparam logic [15:0] VFP_LD    = 16'(VFP_CLKS - 1);
  localparam logic [10:0] LAST_BYTE = 11'(LINE_BYTES - 1);
  localparam logic [9:0]  LAST_LINE = 10'(LINES - 1);

  state_t      state, state_nxt;
  logic [15:0] timer, timer_nxt;
  logic [10:0] byte_cnt, byte_nxt;
  logic [9:0]  line_cnt, line_nxt;
  logic        frame_start, frame_end;

  logic        vsync_q, href_q, busy_q, done_q;
  logic [7:0]  data_q;
  logic [15:0] frame_count_q;

  logic        vsync_nxt, href_nxt, busy_nxt;
  logic [7:0]  data_nxt;
  logic [15:0] count_nxt;

`ifdef DVP_EXT_PIXEL_EN
  logic underflow_q, underflow_nxt;
`endif

  always_ff @(posedge pclk) begin
    if (!reset) begin
      state         <= IDLE;
      timer         <= '0;
      byte_cnt      <= '0;
      line_cnt      <= '0;
      vsync_q       <= 1'b0;
      href_q        <= 1'b0;
      data_q        <= 8'h00;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      frame_count_q <= '0;
`ifdef DVP_EXT_PIXEL_EN
      underflow_q   <= 1'b0;
`endif
    end else begin
      state         <= state_nxt;
      timer         <= timer_nxt;
      byte_cnt      <= byte_nxt;
      line_cnt      <= line_nxt;
      vsync_q       <= vsync_nxt;
      href_q        <= href_nxt;
      data_q        <= data_nxt;
      busy_q        <= busy_nxt;
      done_q        <= frame_end;
      frame_count_q <= count_nxt;
`ifdef DVP_EXT_PIXEL_EN
      underflow_q   <= underflow_nxt;
`endif
    end
  end

  // Timers are loaded with CLKS-1 on entry and the state advances when they reach zero.
  always_comb begin
    state_nxt   = state;
    timer_nxt   = timer;
    byte_nxt    = byte_cnt;
    line_nxt    = line_cnt;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt   = VSYNC;
          timer_nxt   = VSYNC_LD;
          frame_start = 1'b1;
        end
      end
      VSYNC: begin
        if (timer == 16'd0) begin
          state_nxt = VBP;
          timer_nxt = VBP_LD;
        end else begin
          timer_nxt = timer - 16'd1;
        end
      end
      VBP: begin
        if (timer == 16'd0) begin
          state_nxt = ACTIVE;
          byte_nxt  = '0;
          line_nxt  = '0;
        end else begin
          timer_nxt = timer - 16'd1;
        end
      end
      ACTIVE: begin
        if (byte_cnt == LAST_BYTE) begin
          if (line_cnt == LAST_LINE) begin
            state_nxt = VFP;
            timer_nxt = VFP_LD;
          end else begin
            state_nxt = HBLANK;
            timer_nxt = HBLANK_LD;
          end
        end else begin
          byte_nxt = byte_cnt + 11'd1;
        end
      end
      HBLANK: begin
        if (timer == 16'd0) begin
          state_nxt = ACTIVE;
          byte_nxt  = '0;
          line_nxt  = line_cnt + 10'd1;
        end else begin
          timer_nxt = timer - 16'd1;
        end
      end
      VFP: begin
        if (timer == 16'd0) begin
          frame_end = 1'b1;
          if (continuous) begin
            state_nxt   = VSYNC;
            timer_nxt   = VSYNC_LD;
            frame_start = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          timer_nxt = timer - 16'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they land in a register.
  always_comb begin
    vsync_nxt = (state_nxt == VSYNC);
    href_nxt  = (state_nxt == ACTIVE);
    busy_nxt  = (state_nxt != IDLE);
    count_nxt = frame_end ? frame_count_q + 16'd1 : frame_count_q;
`ifdef DVP_EXT_PIXEL_EN
    pix_ready     = href_nxt;
    data_nxt      = (pix_ready && pix_valid) ? pix_data : 8'h00;
    underflow_nxt = frame_start ? 1'b0 : (underflow_q | (pix_ready & ~pix_valid));
`else
    data_nxt  = href_nxt ? (8'(line_nxt) + 8'(byte_nxt)) : 8'h00;
`endif
  end

  assign dvp.vsync   = vsync_q;
  assign dvp.href    = href_q;
  assign dvp.data    = data_q;
  assign busy        = busy_q;
  assign frame_done  = done_q;
  assign frame_count = frame_count_q;
`ifdef DVP_EXT_PIXEL_EN
  assign underflow   = underflow_q;
`endif

endmodule
